// File: rtl/piece_spawner.sv
// Tetromino spawner: one-piece preview fed by a 7-bag randomizer.
// An LFSR proposes candidates; DRAW retries until the bag accepts one.
module piece_spawner #(
    parameter logic [3:0]  SPAWN_X = 4'd3,
    parameter logic [4:0]  SPAWN_Y = 5'd0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    output logic        spawn_valid,
    output logic [0:15] float,
    output logic [3:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [2:0]  piece_type,
    output logic [2:0]  next_type,
    output logic        busy
);

    typedef enum logic {
        S_IDLE,
        S_DRAW
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0]  used_q, used_d;
    logic [2:0]  attempt_q, attempt_d;
    logic [0:15] float_q, float_d;
    logic [3:0]  pos_x_q, pos_x_d;
    logic [4:0]  pos_y_q, pos_y_d;
    logic [2:0]  piece_type_q, piece_type_d;
    logic [2:0]  next_type_q, next_type_d;
    logic        valid_q, valid_d;

    logic [2:0]  cand;
    logic [7:0]  used_ext;
    logic        cand_ok;
    logic [2:0]  lowest_free;
    logic [2:0]  pick;
    logic [6:0]  used_new;
    logic        feedback;

    function automatic logic [0:15] mask_of(input logic [2:0] t);
        logic [0:15] m;
        case (t)
            3'd0:    m = 16'b0000_1111_0000_0000;
            3'd1:    m = 16'b0110_0110_0000_0000;
            3'd2:    m = 16'b0100_1110_0000_0000;
            3'd3:    m = 16'b0110_1100_0000_0000;
            3'd4:    m = 16'b1100_0110_0000_0000;
            3'd5:    m = 16'b1000_1110_0000_0000;
            3'd6:    m = 16'b0010_1110_0000_0000;
            default: m = 16'b0;
        endcase
        return m;
    endfunction

    assign cand     = lfsr_q[2:0];
    // Candidate 7 maps onto a permanently "used" slot so it is always rejected.
    assign used_ext = {1'b1, used_q};
    assign cand_ok  = !used_ext[cand];
    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        lowest_free = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (!used_q[k]) begin
                lowest_free = k[2:0];
            end
        end
    end

    assign pick     = cand_ok ? cand : lowest_free;
    assign used_new = used_q | (7'd1 << pick);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        used_d       = used_q;
        attempt_d    = attempt_q;
        float_d      = float_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        piece_type_d = piece_type_q;
        next_type_d  = next_type_q;
        valid_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (spawn_req) begin
                    float_d      = mask_of(next_type_q);
                    piece_type_d = next_type_q;
                    pos_x_d      = SPAWN_X;
                    pos_y_d      = SPAWN_Y;
                    valid_d      = 1'b1;
                    state_d      = S_DRAW;
                end
            end
            S_DRAW: begin
                lfsr_d = {lfsr_q[14:0], feedback};
                if (cand_ok || attempt_q == 3'd7) begin
                    next_type_d = pick;
                    used_d      = (used_new == 7'h7F) ? 7'h00 : used_new;
                    attempt_d   = 3'd0;
                    state_d     = S_IDLE;
                end else begin
                    attempt_d = attempt_q + 3'd1;
                end
            end
            default: state_d = S_DRAW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_DRAW;
            lfsr_q       <= SEED;
            used_q       <= 7'h00;
            attempt_q    <= 3'd0;
            float_q      <= 16'b0;
            pos_x_q      <= 4'd0;
            pos_y_q      <= 5'd0;
            piece_type_q <= 3'd0;
            next_type_q  <= 3'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            used_q       <= used_d;
            attempt_q    <= attempt_d;
            float_q      <= float_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            piece_type_q <= piece_type_d;
            next_type_q  <= next_type_d;
            valid_q      <= valid_d;
        end
    end

    assign spawn_valid = valid_q;
    assign float       = float_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign piece_type  = piece_type_q;
    assign next_type   = next_type_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/piece_spawner.md
# piece_spawner

Generates each new falling tetromino for the playfield. It keeps a one-piece preview, draws pieces from a 7-bag randomizer driven by an internal LFSR, and on request presents the spawned piece's anchor position and 4x4 block mask. It sits directly upstream of the game-over check and the movement logic: the `float`, `pos_x` and `pos_y` outputs it emits are the piece status those stages consume.

## Interface

- Parameters:
  - SPAWN_X, default 4'd3: anchor column of a freshly spawned piece.
  - SPAWN_Y, default 5'd0: anchor row of a freshly spawned piece.
  - SEED, default 16'hACE1: LFSR value loaded on reset; must be non-zero.
- Ports:
  - clk, input, 1: system clock. One clock domain; everything is on the rising edge.
  - rst, input, 1: reset. It is synchronous and active-high.
  - spawn_req, input, 1: request a new piece. Sampled only in IDLE.
  - spawn_valid, output, 1: one-cycle pulse. Outputs below carry the new piece.
  - float, output, [0:15]: 4x4 mask, row-major; index = row*4+col, row 0 at top.
  - pos_x, output, [3:0]: anchor column.
  - pos_y, output, [4:0]: anchor row.
  - piece_type, output, [2:0]: current piece, 0..6 = I,O,T,S,Z,J,L.
  - next_type, output, [2:0]: preview piece.
  - busy, output, 1: high whenever state != IDLE.

## Operation

- **Masks** (rotation 0; float[0] is the leftmost bit):
  - I 0000_1111_0000_0000
  - O 0110_0110_0000_0000
  - T 0100_1110_0000_0000
  - S 0110_1100_0000_0000
  - Z 1100_0110_0000_0000
  - J 1000_1110_0000_0000
  - L 0010_1110_0000_0000
- **LFSR**: 16-bit Fibonacci. Feedback = l[15]^l[13]^l[12]^l[10], shifted in at bit 0. It advances every cycle in state DRAW and holds otherwise.
- **Bag**: 7-bit `used` mask, bit k set means type k has already been drawn from the current bag.
- **States**: IDLE, DRAW.
  - Reset:
    - state=DRAW; lfsr=SEED; used=0; attempt=0.
    - float=0, pos_x=0, pos_y=0, piece_type=0, next_type=0, spawn_valid=0.
    - The first DRAW fills the preview.
  - IDLE with spawn_req=1:
    - float = mask(next_type); piece_type = next_type.
    - pos_x = SPAWN_X; pos_y = SPAWN_Y.
    - spawn_valid=1 for this one cycle; state goes to DRAW.
  - DRAW:
    - Candidate c = lfsr[2:0]. It is accepted if c<7 and used[c]=0.
    - If attempt==7 and c is rejected, the lowest-index unused type is accepted instead.
    - On accept:
      - next_type=c; used[c] set; attempt cleared; state goes to IDLE.
      - If the resulting used==7'h7F, used is cleared to 0 in the same update.
    - On reject: attempt+1; stay in DRAW.
- **Requests**:
  - spawn_req during DRAW is dropped. There is no queuing, and the requester must wait for busy=0.
  - spawn_req held high in IDLE spawns once, then is ignored until the next IDLE cycle.
- **Output hold**: outputs hold between spawns. pos_x/pos_y are never modified by this block after a spawn.

## Timing

- spawn_req high in IDLE at edge N:
  - spawn_valid and the new float/pos/piece_type are visible after edge N.
  - busy=1 from edge N.
- DRAW lasts 1..8 cycles, so busy drops at most 8 cycles after the spawn.
- spawn_valid-to-next-accepted-request minimum is 2 cycles: one DRAW cycle, then an IDLE sample.
- After rst deasserts, busy clears within ≤8 cycles and no spawn_valid is generated.
- rst asserted mid-DRAW or coincident with spawn_req: rst wins. The reset values apply and the bag and preview are discarded.
- busy is combinational from the state register; all other outputs are registered.

## Test plan

- **Reset then first spawn**:
  - Stimulus: rst for 2 cycles, wait busy=0, pulse spawn_req.
  - Required: spawn_valid for exactly 1 cycle; pos_x=3, pos_y=0; piece_type equals the next_type shown before the request; float matches the table.
- **Bag property**:
  - Stimulus: 14 sequential spawns, each issued after busy=0.
  - Required: piece_type values 1–7 form a permutation of 0..6, and values 8–14 also form a permutation of 0..6.
- **Busy drop**:
  - Stimulus: spawn_req asserted in the cycle after spawn_valid, while busy=1.
  - Required: no spawn_valid, outputs unchanged, next spawn needs a fresh request.
- **Held request**:
  - Stimulus: spawn_req held high for 20 cycles.
  - Required: one spawn_valid per IDLE visit; every gap ≥2 cycles; every DRAW ≤8 cycles.
- **Reset mid-DRAW**:
  - Stimulus: rst asserted the cycle after spawn_valid.
  - Required: float=0, pos_x=0, pos_y=0, piece_type=0, next_type=0, spawn_valid=0, busy=1; lfsr=16'hACE1; the subsequent draw sequence is identical to one after power-on reset.
- **Determinism**:
  - Stimulus: two runs from reset with identical request timing.
  - Required: identical piece_type sequences.
